hcsr04_echo_emulator: RTL and testbench
=======================================

HCSR04_ECHO_EMULATOR -- requirements
Module: hcsr04_echo_emulator

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000; system clock frequency.
REQ-002 Parameter MIN_TRIG_US, default 10; minimum qualifying trigger high time, in microseconds.
REQ-003 Parameter BURST_US, default 200; emulated 8-cycle 40 kHz burst delay between trigger fall and echo rise.
REQ-004 Parameter TIMEOUT_US, default 38000; echo width reported for no object or out of range.
REQ-005 Parameter HOLDOFF_US, default 1000; dead time after echo fall before the next trigger is accepted.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 trigger  input  1  trigger pulse from the measurement initiator; synchronous to clk.
REQ-009 distance_cm  input  9  emulated target distance in cm; sampled once per measurement.
REQ-010 echo  output  1  emulated echo pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 trig_err  output  1  one-cycle pulse when a trigger is rejected as too short.

Function
REQ-013 CLK_PER_US = CLK_FREQ_HZ/1_000_000 shall be an integer; a 1 us tick shall be generated by a prescaler that restarts at zero on every state entry.
REQ-014 The FSM shall have the states IDLE, TRIG_HI, BURST, ECHO_HI, and HOLDOFF.
REQ-015 IDLE: when trigger rises (registered previous value 0, current 1), the FSM shall go to TRIG_HI and clear the trigger-width cycle counter.
REQ-016 TRIG_HI: the counter shall increment once per clk while trigger=1, saturating at MIN_TRIG_US*CLK_PER_US.
REQ-017 TRIG_HI: when trigger falls and the count >= MIN_TRIG_US*CLK_PER_US, the block shall latch distance_cm in the same cycle and go to BURST.
REQ-018 TRIG_HI: when trigger falls and the count is below the threshold, trig_err shall pulse for exactly one cycle and the FSM shall return to IDLE.
REQ-019 BURST shall last exactly BURST_US*CLK_PER_US cycles, then go to ECHO_HI.
REQ-020 echo shall be registered and high exactly while in ECHO_HI, so echo rises on the first cycle after BURST.
REQ-021 Echo width shall be W = latched_cm*58 us when 2 <= latched_cm <= 400.
REQ-022 W shall be TIMEOUT_US when latched_cm is 0 or greater than 400.
REQ-023 W shall be 2*58 = 116 us when latched_cm is 1 (minimum-range clamp).
REQ-024 The width computation shall use a 16-bit unsigned microsecond count; the product 9-bit × 58 shall be computed without truncation (max 23200).
REQ-025 ECHO_HI shall last exactly W*CLK_PER_US cycles, then go to HOLDOFF.
REQ-026 HOLDOFF shall last exactly HOLDOFF_US*CLK_PER_US cycles, then go to IDLE.
REQ-027 Trigger activity in BURST, ECHO_HI, or HOLDOFF shall be ignored, with no trig_err and no restart.
REQ-028 A trigger already high on entry to IDLE shall not start a measurement; only a fresh rising edge qualifies.
REQ-029 Changes to distance_cm after latching shall not affect the measurement in progress.
REQ-030 If trigger rises and falls in the same cycle that HOLDOFF exits, the event shall be ignored.

Reset
REQ-031 While reset=0 at a clk edge, the following shall take effect at that edge: state=IDLE; echo=0; busy=0; trig_err=0; all counters=0; latched distance=0; registered trigger=0.
REQ-032 Reset asserted mid-measurement (any state) shall abort the measurement and drop echo to 0 on the same clock edge.
REQ-033 After release, the first measurement shall require a fresh trigger rising edge.

Structure
REQ-034 A shared package hcsr04_pkg shall hold the FSM state encoding, the 58 us/cm constant, the 2 and 400 cm range limits, and the distance and microsecond-count widths.
REQ-035 One sub-module, hcsr04_us_tick, shall provide the restartable 1 us tick prescaler; all other logic shall be in the top module.

Verification
REQ-036 trigger high 1000 cycles, distance_cm=10 -> echo rises 20000 cycles after trigger fall and stays high exactly 58000 cycles; busy is high throughout.
REQ-037 trigger high 999 cycles -> trig_err is high for exactly 1 cycle after the fall; echo stays 0; the FSM returns to IDLE.
REQ-038 distance_cm=0 and, separately, distance_cm=401 -> echo high exactly 3_800_000 cycles.
REQ-039 distance_cm=400 -> echo width 2_320_000 cycles; distance_cm=1 -> echo width 11600 cycles.
REQ-040 Second trigger during ECHO_HI, plus distance_cm changed to 50 -> no effect on the current pulse; a trigger after HOLDOFF (100000 cycles) yields a 290000-cycle echo.
REQ-041 reset=0 for one cycle mid-ECHO_HI -> echo is 0 after that edge; after reset=1, a new qualifying trigger produces a correct echo.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// HC-SR04 echo emulator shared definitions.
// State encoding, range constants and width helper.
package hcsr04_pkg;

  localparam int DIST_W = 9;
  localparam int US_W   = 16;

  localparam logic [US_W-1:0]   US_PER_CM = 16'd58;
  localparam logic [DIST_W-1:0] MIN_CM    = 9'd2;
  localparam logic [DIST_W-1:0] MAX_CM    = 9'd400;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO_HI,
    HOLDOFF
  } state_t;

  // Echo width in microseconds for a latched distance.
  // 9-bit x 58 peaks at 23200, so 16 bits never truncate.
  function automatic logic [US_W-1:0] echo_width_us(
    input logic [DIST_W-1:0] cm,
    input logic [US_W-1:0]   timeout_us
  );
    logic [US_W-1:0] w;
    if (cm == '0 || cm > MAX_CM)
      w = timeout_us;
    else if (cm < MIN_CM)
      w = US_W'(MIN_CM) * US_PER_CM;
    else
      w = US_W'(cm) * US_PER_CM;
    return w;
  endfunction

endpackage

// File: rtl/hcsr04_us_tick.sv
// Restartable 1 us tick prescaler.
// restart marks the first cycle of a new state.
module hcsr04_us_tick
  import hcsr04_pkg::*;
#(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int PW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] count;
  logic [PW-1:0] count_eff;

  // A restart cycle counts as phase zero.
  assign count_eff = restart ? '0 : count;
  assign tick      = (count_eff == LAST);

  // Free-running phase counter, wrapping on each tick.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count_eff + PW'(1);
  end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor echo emulator.
// Trigger qualify, burst delay, echo pulse, holdoff.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_err
);

  localparam int CLK_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_CYC   = MIN_TRIG_US * CLK_PER_US;
  localparam int CW         = $clog2(TRIG_CYC + 1);

  localparam logic [CW-1:0] TRIG_MAX  = CW'(TRIG_CYC);
  // The rise cycle itself is high but not counted.
  localparam logic [CW-1:0] TRIG_QUAL = CW'(TRIG_CYC - 1);

  localparam logic [US_W-1:0] BURST_LAST =
    US_W'(BURST_US - 1);
  localparam logic [US_W-1:0] HOLD_LAST =
    US_W'(HOLDOFF_US - 1);
  localparam logic [US_W-1:0] TIMEOUT =
    US_W'(TIMEOUT_US);

  state_t            state;
  logic              trig_r;
  logic [CW-1:0]     trig_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [DIST_W-1:0] dist_q;
  logic              restart;
  logic              tick;
  logic [US_W-1:0]   echo_last;

  assign echo_last =
    echo_width_us(dist_q, TIMEOUT) - US_W'(1);

  hcsr04_us_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
      trig_r   <= 1'b0;
      trig_cnt <= '0;
      us_cnt   <= '0;
      dist_q   <= '0;
      restart  <= 1'b0;
    end else begin
      trig_r   <= trigger;
      trig_err <= 1'b0;
      restart  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger && !trig_r) begin
            state    <= TRIG_HI;
            trig_cnt <= '0;
            busy     <= 1'b1;
            restart  <= 1'b1;
          end
        end
        TRIG_HI: begin
          if (trigger) begin
            if (trig_cnt != TRIG_MAX)
              trig_cnt <= trig_cnt + CW'(1);
          end else if (trig_cnt >= TRIG_QUAL) begin
            dist_q  <= distance_cm;
            state   <= BURST;
            us_cnt  <= '0;
            restart <= 1'b1;
          end else begin
            trig_err <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            restart  <= 1'b1;
          end
        end
        BURST: begin
          if (tick) begin
            if (us_cnt == BURST_LAST) begin
              state   <= ECHO_HI;
              echo    <= 1'b1;
              us_cnt  <= '0;
              restart <= 1'b1;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        ECHO_HI: begin
          if (tick) begin
            if (us_cnt == echo_last) begin
              state   <= HOLDOFF;
              echo    <= 1'b0;
              us_cnt  <= '0;
              restart <= 1'b1;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        HOLDOFF: begin
          if (tick) begin
            if (us_cnt == HOLD_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              us_cnt  <= '0;
              restart <= 1'b1;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          echo  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Self-checking bench for hcsr04_echo_emulator.
// Timeline reference model plus literal pins.
module tb_hcsr04_echo_emulator;

  localparam int CPU  = 2;
  localparam int MTU  = 3;
  localparam int BUS  = 5;
  localparam int TOU  = 150;
  localparam int HOU  = 20;
  localparam int THR  = MTU * CPU;
  localparam int BCYC = BUS * CPU;
  localparam int HCYC = HOU * CPU;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;

  hcsr04_echo_emulator #(
    .CLK_FREQ_HZ(CPU * 1_000_000),
    .MIN_TRIG_US(MTU),
    .BURST_US   (BUS),
    .TIMEOUT_US (TOU),
    .HOLDOFF_US (HOU)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_print  = 0;
  int cyc      = 0;

  bit m_prev, m_pulse, m_active;
  int m_len, m_echo_s, m_echo_e, m_idle_at, m_fall_k;
  bit exp_echo, exp_busy, exp_err;

  int run = 0, last_width = 0, rise_k = 0;
  int pulses = 0, err_cnt = 0;
  bit echo_p = 0;

  function automatic int width_cyc(int d);
    if (d == 0 || d > 400) return TOU * CPU;
    if (d < 2) return 2 * 58 * CPU;
    return d * 58 * CPU;
  endfunction

  task automatic check(string name, int got, int want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d",
               name, got, want);
    end
  endtask

  // Reference model: the measurement as a timeline.
  task automatic model_step();
    bit err;
    cyc++;
    err = 0;
    if (!reset) begin
      m_prev = 0; m_pulse = 0; m_active = 0;
      m_len = 0;
    end else begin
      if (m_pulse) begin
        if (trigger) m_len++;
        else begin
          m_pulse  = 0;
          m_fall_k = cyc;
          if (m_len >= THR) begin
            m_active  = 1;
            m_echo_s  = cyc + BCYC;
            m_echo_e  = m_echo_s +
                        width_cyc(int'(distance_cm));
            m_idle_at = m_echo_e + HCYC;
          end else err = 1;
        end
      end else if ((!m_active || cyc > m_idle_at)
                   && trigger && !m_prev) begin
        m_pulse  = 1;
        m_len    = 1;
        m_active = 0;
      end
      m_prev = trigger;
    end
    exp_busy = m_pulse ||
               (m_active && cyc < m_idle_at);
    exp_echo = m_active && cyc >= m_echo_s &&
               cyc < m_echo_e;
    exp_err  = err;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare and echo pulse monitor.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      n_assert++;
      if (echo !== exp_echo || busy !== exp_busy ||
          trig_err !== exp_err) begin
        n_fail++;
        if (n_print < 20)
          $display("FAIL cyc%0d echo/busy/err got %b%b%b want %b%b%b",
                   cyc, echo, busy, trig_err,
                   exp_echo, exp_busy, exp_err);
        n_print++;
      end
      if (echo === 1'b1 && !echo_p) begin
        rise_k = cyc;
        run    = 1;
      end else if (echo === 1'b1) run++;
      if (echo !== 1'b1 && echo_p) begin
        last_width = run;
        pulses++;
      end
      echo_p = (echo === 1'b1);
      if (trig_err === 1'b1) err_cnt++;
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k >= 60000) begin
      n_assert++;
      n_fail++;
      $display("FAIL wait_idle busy stuck got 1 want 0");
    end
  endtask

  task automatic pulse(int len, int d);
    distance_cm = 9'(d);
    trigger = 1;
    repeat (len) @(negedge clk);
    trigger = 0;
  endtask

  task automatic measure(int len, int d);
    pulse(len, d);
    wait_idle();
  endtask

  int p0, e0, d;

  initial begin
    reset = 0; trigger = 0; distance_cm = 0;
    repeat (3) @(negedge clk);
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(trig_err), 0);
    reset = 1;
    repeat (3) @(negedge clk);

    check("model_w10", width_cyc(10), 1160);
    check("model_w1", width_cyc(1), 232);

    measure(THR, 10);
    check("delay_d10", rise_k - m_fall_k, 10);
    check("width_d10", last_width, 1160);

    p0 = pulses; e0 = err_cnt;
    measure(THR - 1, 10);
    repeat (2) @(negedge clk);
    check("short_err", err_cnt - e0, 1);
    check("short_noecho", pulses - p0, 0);

    measure(THR, 0);
    check("width_d0", last_width, 300);
    measure(THR, 401);
    check("width_d401", last_width, 300);
    measure(THR, 1);
    check("width_d1", last_width, 232);
    measure(THR, 400);
    check("width_d400", last_width, 46400);

    pulse(THR, 10);
    repeat (40) @(negedge clk);
    trigger = 1; distance_cm = 50;
    repeat (8) @(negedge clk);
    trigger = 0;
    wait_idle();
    check("ignore_width", last_width, 1160);
    measure(THR, 50);
    check("width_d50", last_width, 5800);

    pulse(THR, 10);
    repeat (200) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_mid_echo", int'(echo), 0);
    reset = 1;
    repeat (3) @(negedge clk);
    measure(THR, 3);
    check("width_after_rst", last_width, 348);

    p0 = pulses;
    pulse(THR, 2);
    repeat (50) @(negedge clk);
    trigger = 1;
    wait_idle();
    repeat (10) @(negedge clk);
    trigger = 0;
    repeat (5) @(negedge clk);
    check("held_trig", pulses - p0, 1);

    p0 = pulses; e0 = err_cnt;
    pulse(THR, 2);
    @(negedge clk);
    for (int k = 0; k < 5000; k++) begin
      if (cyc >= m_idle_at - 1) break;
      @(negedge clk);
    end
    trigger = 1;
    @(negedge clk);
    trigger = 0;
    repeat (20) @(negedge clk);
    check("hold_exit_pulses", pulses - p0, 1);
    check("hold_exit_err", err_cnt - e0, 0);
    check("hold_exit_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(0, 14);
      if (d == 13) d = 401;
      if (d == 14) d = 480;
      pulse($urandom_range(3, 9), d);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        trigger = 1;
        distance_cm = 9'($urandom);
        repeat (2) @(negedge clk);
        trigger = 0;
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
